adder_word_sequencer: RTL and testbench

- Upstream/downstream companion to the 12-bit hybrid RCA/CLA adder.
- Accepts operand words through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Drives the combinational 12-bit adder's A/B/Cin and registers its 13-bit result on a valid/ready output.
- Supports multi-word chaining: carry-out of word k becomes carry-in of word k+1, giving 24/36/...-bit additions through one 12-bit adder.

---
 rtl/adder_word_sequencer.sv | 139 +++++++++++++
 tb/tb_adder_word_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_word_sequencer.sv
// Operand sequencer for a W-bit combinational adder: buffers operand words in a
// small FIFO, drives the adder, registers {cout,sum} and chains carries across words.
module adder_word_sequencer #(
  parameter int W     = 12,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_first,
  input  logic         in_last,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W:0]   add_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_last,
  output logic         busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         is_first;
    logic         is_last;
  } entry_t;

  entry_t         mem_q [DEPTH];
  entry_t         head;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           carry_q, carry_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_sum_q, out_sum_d;
  logic           out_cout_q, out_cout_d;
  logic           out_last_q, out_last_d;
  logic           empty, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign in_ready = (count_q < CW'(DEPTH));
  assign head     = mem_q[rd_ptr_q];
  assign push     = in_valid & in_ready;
  assign pop      = !empty & (!out_valid_q | out_ready);

  // Idle adder inputs are forced to zero so the adder output is quiet when nothing is queued.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (!empty) begin
      add_a   = head.a;
      add_b   = head.b;
      add_cin = head.is_first ? head.cin : carry_q;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_last_d  = out_last_q;

    if (push) wr_ptr_d = next_ptr(wr_ptr_q);

    if (pop) begin
      rd_ptr_d    = next_ptr(rd_ptr_q);
      out_sum_d   = add_y[W-1:0];
      out_cout_d  = add_y[W];
      out_last_d  = head.is_last;
      out_valid_d = 1'b1;
      // The carry chain closes at the last word so a stray continuation word starts from zero.
      carry_d     = head.is_last ? 1'b0 : add_y[W];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_last_q  <= out_last_d;
    end
  end

  // NOTE: FIFO storage is not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: in_a, b: in_b, cin: in_cin, is_first: in_first, is_last: in_last};
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_last  = out_last_q;
  assign busy      = !empty | out_valid_q;

endmodule

// File: tb/tb_adder_word_sequencer.sv
// Bench for adder_word_sequencer: golden adder attached, word-level reference model
// of chained additions, per-cycle compare process plus directed literal expectations.
module tb_adder_word_sequencer;
  localparam int W     = 12;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_cin, in_first, in_last;
  logic [W-1:0] add_a, add_b;
  logic         add_cin;
  logic [W:0]   add_y;
  logic         out_valid, out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout, out_last, busy;

  adder_word_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_first(in_first), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_y(add_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_last(out_last), .busy(busy)
  );

  // Golden combinational adder attached to the sequencer.
  assign add_y = {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: queue of every accepted word's expected result, in order.
  typedef struct {
    logic [W:0] y;
    logic       last;
  } exp_t;

  exp_t q[$];
  logic model_carry = 1'b0;
  int   stall = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      model_carry = 1'b0;
      stall = 0;
    end else begin
      check("busy", 32'(busy), 32'(q.size() != 0));
      check("in_ready", 32'(in_ready), 32'((q.size() - int'(out_valid)) < DEPTH));
      if (out_valid) begin
        stall = 0;
        if (q.size() == 0) begin
          check("out_valid_unexpected", 32'(out_valid), 32'd0);
        end else begin
          check("out_sum", 32'(out_sum), 32'(q[0].y[W-1:0]));
          check("out_cout", 32'(out_cout), 32'(q[0].y[W]));
          check("out_last", 32'(out_last), 32'(q[0].last));
          if (out_ready) void'(q.pop_front());
        end
      end else if (q.size() != 0) begin
        stall++;
        if (stall > 1) check("out_latency", 32'(out_valid), 32'd1);
      end
      if (in_valid && in_ready) begin
        exp_t e;
        logic c;
        c      = in_first ? in_cin : model_carry;
        e.y    = {1'b0, in_a} + {1'b0, in_b} + (W+1)'(c);
        e.last = in_last;
        model_carry = in_last ? 1'b0 : e.y[W];
        q.push_back(e);
      end
    end
  end

  // Drive one word; starts and ends at posedge+1, bounded wait for in_ready.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic f, input logic l);
    in_a = a; in_b = b; in_cin = cin; in_first = f; in_last = l; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
      if (i == 49) check("push_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result word and compare to literal values; ends at posedge+1.
  task automatic wait_out(input string name, input logic [W-1:0] s, input logic c,
                          input logic l, output int waits);
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      waits++;
      if (out_valid) break;
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_sum"}, 32'(out_sum), 32'(s));
    check({name, "_cout"}, 32'(out_cout), 32'(c));
    check({name, "_last"}, 32'(out_last), 32'(l));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_first = 1'b0; in_last = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("idle_add_a", 32'(add_a), 32'd0);
    check("idle_add_b", 32'(add_b), 32'd0);
    check("idle_add_cin", 32'(add_cin), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single add and latency.
    push(12'hFFF, 12'h001, 1'b0, 1'b1, 1'b1);
    wait_out("single", 12'h000, 1'b1, 1'b1, w);
    check("single_latency", 32'(w), 32'd2);

    // Cin path.
    push(12'h7FF, 12'h800, 1'b1, 1'b1, 1'b1);
    wait_out("cin1", 12'h000, 1'b1, 1'b1, w);
    push(12'h7FF, 12'h800, 1'b0, 1'b1, 1'b1);
    wait_out("cin0", 12'hFFF, 1'b0, 1'b1, w);

    // 24-bit chain, then a continuation word after the last word sees carry 0.
    push(12'hFFF, 12'h001, 1'b0, 1'b1, 1'b0);
    push(12'h000, 12'h000, 1'b0, 1'b0, 1'b1);
    wait_out("chain_lo", 12'h000, 1'b1, 1'b0, w);
    wait_out("chain_hi", 12'h001, 1'b0, 1'b1, w);
    push(12'h005, 12'h006, 1'b1, 1'b0, 1'b1);
    wait_out("after_last", 12'h00B, 1'b0, 1'b1, w);

    // Backpressure: three words fill output register plus FIFO; fourth waits.
    out_ready = 1'b0;
    push(12'h001, 12'h002, 1'b0, 1'b1, 1'b1);
    push(12'h010, 12'h020, 1'b0, 1'b1, 1'b1);
    push(12'h100, 12'h200, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_sum", 32'(out_sum), 32'h003);
    check("bp_head_a", 32'(add_a), 32'h010);
    check("bp_head_cin", 32'(add_cin), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    fork
      push(12'hFFF, 12'hFFF, 1'b0, 1'b1, 1'b1);
      begin
        int wt;
        wait_out("bp_w0", 12'h003, 1'b0, 1'b1, wt); check("bp_w0_gap", 32'(wt), 32'd1);
        wait_out("bp_w1", 12'h030, 1'b0, 1'b1, wt); check("bp_w1_gap", 32'(wt), 32'd1);
        wait_out("bp_w2", 12'h300, 1'b0, 1'b1, wt); check("bp_w2_gap", 32'(wt), 32'd1);
        wait_out("bp_w3", 12'hFFE, 1'b1, 1'b1, wt); check("bp_w3_gap", 32'(wt), 32'd1);
      end
    join
    repeat (3) begin @(posedge clk); #1; end

    // Sustained push/pop with random chained words; model checks every cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
      in_first = 1'($urandom); in_last = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
      in_first = 1'($urandom); in_last = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    check("drain_empty", 32'(q.size()), 32'd0);

    // Reset mid-chain after the first word of a 36-bit chain has been added.
    push(12'hFFF, 12'h001, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_sum", 32'(out_sum), 32'd0);
    check("midrst_out_cout", 32'(out_cout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    push(12'h000, 12'h000, 1'b0, 1'b0, 1'b1);
    wait_out("postrst_carry", 12'h000, 1'b0, 1'b1, w);
    push(12'h123, 12'h456, 1'b0, 1'b1, 1'b1);
    wait_out("postrst_single", 12'h579, 1'b0, 1'b1, w);
    repeat (3) begin @(posedge clk); #1; end
    check("final_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
